wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the PC and write-data fields.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have parameter ENDFLAG_REG, default 31, meaning the register index whose nonzero write ends the trace.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as in the codebase.
REQ-005 SHALL provide the following ports:
- clk_in  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous active-low reset
- arm  in  1  start or restart capture (pulse)
- wb_wena_rf  in  1  WB-stage register-file write enable
- wb_waddr  in  5  WB-stage destination register
- wb_wdata  in  DATA_W  WB-stage write data
- wb_pc  in  DATA_W  PC of the committing instruction
- filter_en  in  1  when 1, capture only writes to filter_addr
- filter_addr  in  5  register selected by the filter
- trc_valid  out  1  FIFO head is valid
- trc_ready  in  1  consumer accepts the head entry
- trc_pc  out  DATA_W  head entry PC
- trc_waddr  out  5  head entry destination register
- trc_wdata  out  DATA_W  head entry write data
- commit_cnt  out  32  number of qualifying commits
- drop_cnt  out  16  number of qualifying commits lost because the FIFO was full
- state  out  2  FSM state
- done  out  1  trace complete

Function
REQ-006 SHALL implement FSM states IDLE=0, CAPTURE=1, HALT=2, DONE=3, with state driven from the state register.
REQ-007 SHALL make these FSM transitions:
- IDLE->CAPTURE on arm=1
- CAPTURE->HALT on wb_wena_rf=1 and wb_waddr==ENDFLAG_REG and wb_wdata!=0
- HALT->DONE when the FIFO is empty at the clock edge with no push
- DONE->CAPTURE on arm=1
- arm ignored in CAPTURE and HALT
REQ-008 SHALL treat a commit as qualifying when all hold: state==CAPTURE; wb_wena_rf=1; wb_waddr!=0; and either filter_en=0 or wb_waddr==filter_addr.
REQ-009 SHALL detect the end flag independently of the filter; the end-flag commit is itself captured if it qualifies.
REQ-010 SHALL, on each qualifying commit, increment commit_cnt by 1, saturating at 32'hFFFFFFFF.
REQ-011 SHALL push {wb_pc, wb_waddr, wb_wdata} for a qualifying commit if the FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise the entry is dropped and drop_cnt increments, saturating at 16'hFFFF.
REQ-012 SHALL operate the FIFO first-word-fall-through:
- trc_valid = FIFO not empty
- trc_pc, trc_waddr and trc_wdata show the head entry
- pop when trc_valid && trc_ready
REQ-013 SHALL ignore trc_ready when the FIFO is empty, with no pointer change.
REQ-014 SHALL handle a simultaneous push and pop at any fill level with occupancy unchanged and order preserved.
REQ-015 SHALL use read/write pointers of width log2(DEPTH)+1 that wrap modulo 2*DEPTH:
- full = MSBs differ, low bits equal
- empty = pointers equal
REQ-016 SHALL keep the FIFO draining in HALT and DONE; no pushes occur outside CAPTURE.
REQ-017 SHALL, on DONE->CAPTURE, clear commit_cnt and drop_cnt in the same edge; FIFO contents are unaffected (already empty).
REQ-018 SHALL drive done = (state==DONE), registered.
REQ-019 SHALL give a push-to-trc_valid latency of exactly one clock (entry visible the cycle after the commit edge).

Reset
REQ-020 SHALL, while reset_n=0 (asynchronously), set:
- state=IDLE, done=0
- both pointers 0, so trc_valid=0
- commit_cnt=0, drop_cnt=0
REQ-021 SHALL make trc_pc, trc_waddr and trc_wdata read 0 after reset until the first push.
REQ-022 SHALL discard all buffered entries on a reset asserted mid-capture or mid-drain; the first cycle after release is IDLE.

Verification
REQ-023 SHALL cover: arm, then writes $8=5 @pc 0x0, $9=7 @pc 0x4, trc_ready=1 -> trc outputs (0x0,8,5) then (0x4,9,7); commit_cnt=2; drop_cnt=0.
REQ-024 SHALL cover: trc_ready=0, DEPTH=16, 20 qualifying writes -> trc_valid=1, 16 entries held, commit_cnt=20, drop_cnt=4; first 16 entries drained in order.
REQ-025 SHALL cover: FIFO full, pop and qualifying push in the same cycle -> no drop, occupancy stays 16, new entry arrives last.
REQ-026 SHALL cover: filter_en=1, filter_addr=3; writes to $3, $4, $0 -> only the $3 write captured; commit_cnt=1.
REQ-027 SHALL cover: $31=1 written with filter on $3 and 2 entries buffered -> HALT next cycle; no further capture; DONE one cycle after the last pop; done=1; arm then returns to CAPTURE with both counters 0.
REQ-028 SHALL cover: reset_n pulsed low mid-capture with 5 entries buffered -> trc_valid=0 immediately, state=0, counters 0.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - writeback commit stream in, trace entry stream out
//
// Signals:
//   wb_wena_rf, wb_waddr, wb_wdata, wb_pc : commit seen at the writeback stage
//   trc_valid, trc_ready                   : trace head handshake
//   trc_pc, trc_waddr, trc_wdata           : trace head entry fields
// Modports:
//   master : produces commits and consumes trace entries
//   slave  : the trace buffer itself
interface wb_trace_buffer_if #(
  parameter int DATA_W = 32
);
  logic              wb_wena_rf;
  logic [4:0]        wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] wb_pc;
  logic              trc_valid;
  logic              trc_ready;
  logic [DATA_W-1:0] trc_pc;
  logic [4:0]        trc_waddr;
  logic [DATA_W-1:0] trc_wdata;

  modport master (
    output wb_wena_rf, wb_waddr, wb_wdata, wb_pc, trc_ready,
    input  trc_valid, trc_pc, trc_waddr, trc_wdata
  );

  modport slave (
    input  wb_wena_rf, wb_waddr, wb_wdata, wb_pc, trc_ready,
    output trc_valid, trc_pc, trc_waddr, trc_wdata
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - armed writeback commit tracer with FWFT FIFO and end-flag halt
//
// Ports:
//   clk_in, reset_n       : clock, asynchronous active-low reset
//   arm                   : start capture from IDLE or DONE
//   filter_en/filter_addr : restrict capture to one destination register
//   bus (slave)           : commit inputs and first-word-fall-through trace output
//   commit_cnt, drop_cnt  : saturating qualifying-commit and overflow-drop counters
//   state, done           : FSM state (IDLE/CAPTURE/HALT/DONE), done = state is DONE
module wb_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ENDFLAG_REG = 31
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             filter_en,
  input  logic [4:0]       filter_addr,
  wb_trace_buffer_if.slave bus,
  output logic [31:0]      commit_cnt,
  output logic [15:0]      drop_cnt,
  output logic [1:0]       state,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 * DATA_W + 5;
  localparam logic [4:0] END_ADDR = 5'(ENDFLAG_REG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic          empty, full, pop, push, qualify, end_flag, drop, restart;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = !empty && bus.trc_ready;
  assign qualify  = (state_q == CAPTURE) && bus.wb_wena_rf && (bus.wb_waddr != 5'd0) &&
                    (!filter_en || (bus.wb_waddr == filter_addr));
  // The end flag ignores the filter so a filtered trace can still terminate.
  assign end_flag = (state_q == CAPTURE) && bus.wb_wena_rf && (bus.wb_waddr == END_ADDR) &&
                    (bus.wb_wdata != '0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = qualify && (!full || pop);
  assign drop     = qualify && full && !pop;
  assign restart  = (state_q == DONE) && arm;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (end_flag) state_d = HALT;
      HALT:    if (empty) state_d = DONE;
      DONE:    if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.wb_pc, bus.wb_waddr, bus.wb_wdata};
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else if (restart) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (qualify && (commit_cnt != 32'hFFFF_FFFF)) commit_cnt <= commit_cnt + 32'd1;
      if (drop && (drop_cnt != 16'hFFFF))           drop_cnt   <= drop_cnt + 16'd1;
    end
  end

  // The storage array is not reset; gating with empty keeps the head at zero
  // until something has actually been written.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.trc_valid = !empty;
  assign bus.trc_pc    = empty ? '0 : head[EW-1 -: DATA_W];
  assign bus.trc_waddr = empty ? '0 : head[DATA_W +: 5];
  assign bus.trc_wdata = empty ? '0 : head[DATA_W-1:0];
  assign state         = state_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b1;
  logic        arm = 1'b0;
  logic        filter_en = 1'b0;
  logic [4:0]  filter_addr = 5'd0;
  logic [31:0] commit_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  state;
  logic        done;

  wb_trace_buffer_if #(.DATA_W(32)) bus ();

  wb_trace_buffer #(.DATA_W(32), .DEPTH(DEPTH), .ENDFLAG_REG(31)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .arm         (arm),
    .filter_en   (filter_en),
    .filter_addr (filter_addr),
    .bus         (bus),
    .commit_cnt  (commit_cnt),
    .drop_cnt    (drop_cnt),
    .state       (state),
    .done        (done)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the trace is a queue of committed entries, the mode a small integer.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t    q[$];
  int      m_state = 0;
  longint  m_cnt = 0;
  int      m_drop = 0;
  bit      m_pushed = 0;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_state = 0;
      m_cnt = 0;
      m_drop = 0;
      m_pushed = 0;
    end else begin
      int  sz0;
      bit  popm, qual, endf;
      sz0  = q.size();
      popm = (sz0 > 0) && bus.trc_ready;
      qual = (m_state == 1) && bus.wb_wena_rf && (bus.wb_waddr != 0) &&
             (!filter_en || bus.wb_waddr == filter_addr);
      endf = (m_state == 1) && bus.wb_wena_rf && (bus.wb_waddr == 31) && (bus.wb_wdata != 0);
      if (popm) void'(q.pop_front());
      if (qual) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (sz0 < DEPTH || popm) begin
          q.push_back('{pc: bus.wb_pc, a: bus.wb_waddr, d: bus.wb_wdata});
          m_pushed = 1;
        end else if (m_drop < 16'hFFFF) m_drop++;
      end
      case (m_state)
        0: if (arm) m_state = 1;
        1: if (endf) m_state = 2;
        2: if (sz0 == 0) m_state = 3;
        default: if (arm) begin
          m_state = 1;
          m_cnt = 0;
          m_drop = 0;
        end
      endcase
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("trc_valid", bus.trc_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("trc_pc", bus.trc_pc, q[0].pc);
        chk("trc_waddr", bus.trc_waddr, q[0].a);
        chk("trc_wdata", bus.trc_wdata, q[0].d);
      end else if (!m_pushed) begin
        chk("trc_fields_zero", {bus.trc_pc, bus.trc_waddr, bus.trc_wdata[26:0]}, 64'd0);
      end
      chk("commit_cnt", commit_cnt, m_cnt);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("state", state, m_state);
      chk("done", done, m_state == 3);
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.wb_wena_rf = 1'b1;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
    bus.wb_pc = pc;
    cyc();
    bus.wb_wena_rf = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #3 reset_n = 1'b0;
    @(posedge clk_in);
    #2 reset_n = 1'b1;
    filter_en = 1'b0;
    arm = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    int r;
    bus.wb_wena_rf = 1'b0;
    bus.wb_waddr = '0;
    bus.wb_wdata = '0;
    bus.wb_pc = '0;
    bus.trc_ready = 1'b0;
    #2 reset_n = 1'b0;
    cmp_en = 1;
    cyc();
    cyc();
    chk("rst_state", state, 0);
    chk("rst_valid", bus.trc_valid, 0);
    chk("rst_counts", {commit_cnt, drop_cnt}, 0);
    chk("rst_pc", bus.trc_pc, 0);
    #1 reset_n = 1'b1;
    cyc();
    chk("idle_hold", state, 0);

    // Two commits drained immediately.
    do_arm();
    chk("armed", state, 1);
    bus.trc_ready = 1'b1;
    bus.wb_wena_rf = 1'b1;
    bus.wb_waddr = 5'd8; bus.wb_wdata = 32'd5; bus.wb_pc = 32'h0;
    cyc();
    chk("e1", {bus.trc_valid, bus.trc_pc[15:0], 3'b0, bus.trc_waddr, bus.trc_wdata[15:0]}, {1'b1, 16'h0, 3'b0, 5'd8, 16'd5});
    bus.wb_waddr = 5'd9; bus.wb_wdata = 32'd7; bus.wb_pc = 32'h4;
    cyc();
    chk("e2", {bus.trc_valid, bus.trc_pc[15:0], 3'b0, bus.trc_waddr, bus.trc_wdata[15:0]}, {1'b1, 16'h4, 3'b0, 5'd9, 16'd7});
    bus.wb_wena_rf = 1'b0;
    cyc();
    chk("two_cnt", commit_cnt, 2);
    chk("two_drop", drop_cnt, 0);
    chk("two_empty", bus.trc_valid, 0);

    // Overflow: 20 commits into 16 entries, then full push+pop, then drain in order.
    do_reset();
    do_arm();
    bus.trc_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(5'(1 + i % 30), 32'(i + 100), 32'(i * 4));
    chk("ovf_cnt", commit_cnt, 20);
    chk("ovf_drop", drop_cnt, 4);
    chk("ovf_model_occ", q.size(), 16);
    chk("ovf_head", bus.trc_pc, 0);
    bus.trc_ready = 1'b1;
    wr(5'd5, 32'hABC, 32'h100);
    bus.trc_ready = 1'b0;
    chk("full_pp_drop", drop_cnt, 4);
    chk("full_pp_cnt", commit_cnt, 21);
    bus.trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_pc", bus.trc_pc, (i < 15) ? 32'((i + 1) * 4) : 32'h100);
      cyc();
    end
    chk("drained", bus.trc_valid, 0);

    // Filter on $3.
    do_reset();
    do_arm();
    bus.trc_ready = 1'b0;
    filter_en = 1'b1; filter_addr = 5'd3;
    wr(5'd3, 32'h33, 32'h10);
    wr(5'd4, 32'h44, 32'h14);
    wr(5'd0, 32'h55, 32'h18);
    chk("flt_cnt", commit_cnt, 1);
    chk("flt_head", bus.trc_waddr, 3);

    // End flag with two buffered entries.
    do_reset();
    do_arm();
    bus.trc_ready = 1'b0;
    filter_en = 1'b1; filter_addr = 5'd3;
    wr(5'd3, 32'h1, 32'h20);
    wr(5'd3, 32'h2, 32'h24);
    wr(5'd31, 32'h1, 32'h28);
    chk("halt", state, 2);
    wr(5'd3, 32'h3, 32'h2C);
    chk("halt_nocap", commit_cnt, 2);
    bus.trc_ready = 1'b1;
    cyc();
    cyc();
    chk("halt_empty", {bus.trc_valid, 2'b0, state}, 4'h2);
    cyc();
    chk("done_state", state, 3);
    chk("done_flag", done, 1);
    bus.trc_ready = 1'b0;
    do_arm();
    chk("rearm_state", state, 1);
    chk("rearm_cnt", {commit_cnt, drop_cnt}, 0);

    // Asynchronous reset mid-capture with five entries.
    do_reset();
    do_arm();
    for (int i = 0; i < 5; i++) wr(5'(i + 1), 32'(i + 1), 32'(i * 4));
    chk("pre_rst_cnt", commit_cnt, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.trc_valid, 0);
    chk("arst_state", state, 0);
    chk("arst_cnt", {commit_cnt, drop_cnt}, 0);
    #3 reset_n = 1'b1;
    cyc();
    chk("post_rst_idle", state, 0);

    // Randomized traffic against the model.
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        rdy_pct = $urandom_range(5, 95);
        filter_en = ($urandom % 2) == 1;
        filter_addr = 5'($urandom_range(1, 6));
      end
      if (c == 2000) do_reset();
      arm = ($urandom % 20) == 0;
      bus.wb_wena_rf = ($urandom % 4) != 0;
      r = $urandom % 16;
      bus.wb_waddr = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 6));
      bus.wb_wdata = (($urandom % 4) == 0) ? 32'd0 : $urandom;
      bus.wb_pc = $urandom;
      bus.trc_ready = ($urandom % 100) < rdy_pct;
      cyc();
    end
    arm = 1'b0;
    bus.wb_wena_rf = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
